// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// Carries ID/EX/MEM hazard inputs, stage enables/flushes, FSM status and perf counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_syscall;
    logic             id_halt_req;
    logic             ex_regwrite;
    logic             mem_regwrite;
    logic [4:0]       ex_wbreg;
    logic [4:0]       mem_wbreg;
    logic             ex_branch_taken;
    logic             go;

    logic             if_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_syscall,
               id_halt_req, ex_regwrite, mem_regwrite, ex_wbreg, mem_wbreg,
               ex_branch_taken, go,
        input  if_en, ifid_en, ifid_flush, idex_flush, halted, state,
               cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_syscall,
               id_halt_req, ex_regwrite, mem_regwrite, ex_wbreg, mem_wbreg,
               ex_branch_taken, go,
        output if_en, ifid_en, ifid_flush, idex_flush, halted, state,
               cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: RAW interlock vs EX/MEM, wrong-path kill, SYSCALL halt/drain/resume.
// Enables/flushes are combinational (same cycle); optional counters under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               CLR,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_DRAIN = 2'b01,
        S_HALT  = 2'b10
    } state_e;

    state_e     state_q;
    logic [1:0] drain_q;
    logic       halted_q;

    logic rs_hit, rt_hit, raw, halt_start;

    assign rs_hit = bus.id_uses_rs && (bus.id_rs != 5'd0) &&
                    ((bus.ex_regwrite  && (bus.ex_wbreg  == bus.id_rs)) ||
                     (bus.mem_regwrite && (bus.mem_wbreg == bus.id_rs)));
    assign rt_hit = bus.id_uses_rt && (bus.id_rt != 5'd0) &&
                    ((bus.ex_regwrite  && (bus.ex_wbreg  == bus.id_rt)) ||
                     (bus.mem_regwrite && (bus.mem_wbreg == bus.id_rt)));
    assign raw    = rs_hit || rt_hit;

    // A taken branch outranks everything else: the ID slot is wrong-path.
    assign halt_start = CLR && (state_q == S_RUN) && !bus.ex_branch_taken && !raw &&
                        bus.id_syscall && bus.id_halt_req;

    always_comb begin
        bus.if_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b1;
        if (!CLR) begin
            bus.ifid_flush = 1'b1;
        end else if (state_q == S_RUN) begin
            if (bus.ex_branch_taken) begin
                bus.if_en      = 1'b1;
                bus.ifid_en    = 1'b1;
                bus.ifid_flush = 1'b1;
            end else if (raw) begin
                bus.idex_flush = 1'b1;
            end else if (bus.id_syscall && bus.id_halt_req) begin
                // PC stays at syscall+4 so resume refetches from there.
                bus.ifid_en    = 1'b1;
                bus.ifid_flush = 1'b1;
            end else if (bus.id_jump) begin
                bus.if_en      = 1'b1;
                bus.ifid_en    = 1'b1;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b0;
            end else begin
                bus.if_en      = 1'b1;
                bus.ifid_en    = 1'b1;
                bus.idex_flush = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_q  <= S_RUN;
            drain_q  <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (halt_start) begin
                        state_q <= S_DRAIN;
                        drain_q <= 2'd3;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q - 2'd1;
                    if (drain_q == 2'd1) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (bus.go) begin
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_RUN;
                    drain_q  <= 2'd0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state  = state_q;
    assign bus.halted = halted_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
    logic             stall_cyc, flush_cyc;

    assign stall_cyc = (state_q == S_RUN) && !bus.ex_branch_taken && raw;
    assign flush_cyc = (state_q == S_RUN) && (bus.ex_branch_taken ||
                       (!raw && !(bus.id_syscall && bus.id_halt_req) && bus.id_jump));

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q != S_HALT) && (cyc_q != '1)) cyc_q   <= cyc_q + CNT_ONE;
            if (stall_cyc && (stall_q != '1))         stall_q <= stall_q + CNT_ONE;
            if (flush_cyc && (flush_q != '1))         flush_q <= flush_q + CNT_ONE;
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule
